sd_slv_rd_seq: RTL and testbench

Read-transfer sequencer for the SD slave data path.
- Accepts a single- or multi-block read command from the slave command decoder.
- Drives the ROM address generator one block at a time: start pulse, start address, byte length, bus width.
- Waits for the generator's end-of-CRC indication, inserts the inter-block Nac gap, and advances the address.
- Handles the stop command and a per-block watchdog, and reports block completion, done and error to the card state logic.

---
 rtl/sd_slv_pkg.sv | 13 +
 rtl/sd_slv_rd_wdog.sv | 17 +
 rtl/sd_slv_rd_seq.sv | 124 ++++++++++++
 tb/tb_sd_slv_rd_seq.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/sd_slv_pkg.sv
// sd_slv_pkg: shared encodings and widths for the SD slave data path
package sd_slv_pkg;
    localparam int ADDR_W = 10;
    localparam logic [1:0] BW_1BIT = 2'b00;
    localparam logic [1:0] BW_4BIT = 2'b10;
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GAP   = 3'd1,
        S_ISSUE = 3'd2,
        S_XFER  = 3'd3,
        S_FIN   = 3'd4
    } rd_state_t;
endpackage

// File: rtl/sd_slv_rd_wdog.sv
// sd_slv_rd_wdog: clear/increment watchdog flagging terminal count at all-ones
module sd_slv_rd_wdog #(
    parameter int TMO_W = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic tc
);
    logic [TMO_W-1:0] cnt;
    // clear wins over increment so a fresh block always starts from zero
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else cnt <= clr ? '0 : (inc ? cnt + 1'b1 : cnt);
    assign tc = &cnt;
endmodule

// File: rtl/sd_slv_rd_seq.sv
// sd_slv_rd_seq: block-by-block read sequencer driving the ROM address generator
module sd_slv_rd_seq
    import sd_slv_pkg::*;
#(
    parameter int NAC_GAP = 8,
    parameter int TMO_W   = 16,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_start,
    input  logic              cmd_multi,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [9:0]        cmd_len,
    input  logic [1:0]        cmd_bw,
    input  logic              stop_req,
    input  logic              adg_stop_en,
    output logic              adg_read,
    output logic [ADDR_W-1:0] adg_ldad,
    output logic [9:0]        adg_adln,
    output logic [1:0]        adg_bw,
    output logic              busy,
    output logic              blk_done,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  blk_cnt
);
    rd_state_t         state, state_d;
    logic [7:0]        gap;
    logic              multi, stop_pend;
    logic [ADDR_W-1:0] cur_addr;
    logic [9:0]        len;
    logic [1:0]        bw;
    logic              acc, bad, blk_end, tmo, tc;

    sd_slv_rd_wdog #(.TMO_W(TMO_W)) u_wdog (
        .clk(clk),
        .rst(rst),
        .clr(state == S_ISSUE),
        .inc(state == S_XFER),
        .tc (tc)
    );

    // state register
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= S_IDLE;
        else state <= state_d;

    // next state and per-cycle events; block end takes priority over timeout
    always_comb begin
        state_d = state;
        acc     = 1'b0;
        bad     = 1'b0;
        blk_end = 1'b0;
        tmo     = 1'b0;
        case (state)
            S_IDLE: if (cmd_start) begin
                acc     = (cmd_len != '0) && (cmd_bw == BW_1BIT || cmd_bw == BW_4BIT);
                bad     = !acc;
                state_d = acc ? S_GAP : S_IDLE;
            end
            S_GAP:   state_d = stop_req ? S_FIN : (gap == 8'd1 ? S_ISSUE : S_GAP);
            S_ISSUE: state_d = S_XFER;
            S_XFER: begin
                blk_end = adg_stop_en;
                tmo     = !adg_stop_en && tc;
                state_d = adg_stop_en ? ((!multi || stop_pend || stop_req) ? S_FIN : S_GAP)
                                      : (tc ? S_IDLE : S_XFER);
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // registered outputs and datapath: command latch, gap count, address advance
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            adg_read  <= 1'b0;
            adg_ldad  <= '0;
            adg_adln  <= '0;
            adg_bw    <= '0;
            busy      <= 1'b0;
            blk_done  <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            blk_cnt   <= '0;
            gap       <= '0;
            multi     <= 1'b0;
            stop_pend <= 1'b0;
            cur_addr  <= '0;
            len       <= '0;
            bw        <= '0;
        end else begin
            adg_read <= state == S_ISSUE;
            blk_done <= blk_end;
            done     <= state == S_FIN;
            err      <= bad || tmo;
            if (state == S_GAP) gap <= gap - 8'd1;
            if (state == S_ISSUE) begin
                adg_ldad <= cur_addr;
                adg_adln <= len;
                adg_bw   <= bw;
            end
            if ((state == S_ISSUE || state == S_XFER) && stop_req) stop_pend <= 1'b1;
            if (blk_end) begin
                blk_cnt <= &blk_cnt ? blk_cnt : blk_cnt + 1'b1;
                if (state_d == S_GAP) begin
                    cur_addr <= cur_addr + {len[8:0], 1'b0};
                    gap      <= 8'(NAC_GAP);
                end
            end
            if (tmo || state == S_FIN) busy <= 1'b0;
            if (acc) begin
                multi     <= cmd_multi;
                cur_addr  <= cmd_addr;
                len       <= cmd_len;
                bw        <= cmd_bw;
                blk_cnt   <= '0;
                stop_pend <= 1'b0;
                busy      <= 1'b1;
                gap       <= 8'(NAC_GAP);
            end
        end
endmodule

// File: tb/tb_sd_slv_rd_seq.sv
// tb_sd_slv_rd_seq: directed checks of the read sequencer with NAC_GAP=8, TMO_W=4
module tb_sd_slv_rd_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_start = 1'b0, cmd_multi = 1'b0, stop_req = 1'b0, adg_stop_en = 1'b0;
    logic [9:0]  cmd_addr = '0, cmd_len = '0;
    logic [1:0]  cmd_bw = '0;
    logic        adg_read, busy, blk_done, done, err;
    logic [9:0]  adg_ldad, adg_adln;
    logic [1:0]  adg_bw;
    logic [15:0] blk_cnt;
    int          checks = 0, errors = 0;
    int          n, seen;

    sd_slv_rd_seq #(.NAC_GAP(8), .TMO_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_multi(cmd_multi),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_bw(cmd_bw), .stop_req(stop_req),
        .adg_stop_en(adg_stop_en), .adg_read(adg_read), .adg_ldad(adg_ldad),
        .adg_adln(adg_adln), .adg_bw(adg_bw), .busy(busy), .blk_done(blk_done),
        .done(done), .err(err), .blk_cnt(blk_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic send_cmd(input logic m, input logic [9:0] a, input logic [9:0] l, input logic [1:0] b);
        cmd_multi = m; cmd_addr = a; cmd_len = l; cmd_bw = b; cmd_start = 1'b1;
        tick;
        cmd_start = 1'b0;
    endtask

    task automatic wait_rd(output int cnt);
        cnt = 0;
        while (!adg_read && cnt < 60) begin
            tick;
            cnt++;
        end
    endtask

    task automatic end_blk;
        adg_stop_en = 1'b1;
        tick;
        adg_stop_en = 1'b0;
    endtask

    task automatic pulse_stop;
        stop_req = 1'b1;
        tick;
        stop_req = 1'b0;
    endtask

    initial begin
        tick; tick;
        check("rst_busy", busy, 0);
        check("rst_read", adg_read, 0);
        check("rst_cnt", blk_cnt, 0);
        check("rst_err", err, 0);
        rst = 1'b0;
        tick;
        // single block
        send_cmd(1'b0, 10'h010, 10'd16, 2'b10);
        check("s_busy", busy, 1);
        wait_rd(n);
        check("s_lat", n, 9);
        check("s_ldad", adg_ldad, 10'h010);
        check("s_adln", adg_adln, 10'd16);
        check("s_bw", adg_bw, 2'b10);
        tick;
        check("s_read_1cyc", adg_read, 0);
        end_blk;
        check("s_blk_done", blk_done, 1);
        check("s_blk_cnt", blk_cnt, 1);
        check("s_done_early", done, 0);
        tick;
        check("s_done", done, 1);
        check("s_busy_lo", busy, 0);
        tick;
        check("s_done_1cyc", done, 0);
        // multi block, three blocks, stop during the third
        send_cmd(1'b1, 10'h000, 10'd64, 2'b10);
        wait_rd(n);
        check("m_lat1", n, 9);
        check("m_ldad1", adg_ldad, 10'h000);
        tick;
        end_blk;
        check("m_cnt1", blk_cnt, 1);
        wait_rd(n);
        check("m_lat2", n, 9);
        check("m_ldad2", adg_ldad, 10'h080);
        tick;
        end_blk;
        check("m_cnt2", blk_cnt, 2);
        wait_rd(n);
        check("m_ldad3", adg_ldad, 10'h100);
        tick;
        pulse_stop;
        check("m_busy", busy, 1);
        end_blk;
        check("m_blk_done3", blk_done, 1);
        check("m_cnt3", blk_cnt, 3);
        tick;
        check("m_done", done, 1);
        check("m_busy_lo", busy, 0);
        // address wrap, then stop in the following gap
        send_cmd(1'b1, 10'h3F0, 10'd16, 2'b00);
        wait_rd(n);
        check("w_ldad1", adg_ldad, 10'h3F0);
        tick;
        end_blk;
        wait_rd(n);
        check("w_ldad2", adg_ldad, 10'h010);
        tick;
        end_blk;
        pulse_stop;
        tick;
        check("w_done", done, 1);
        check("w_cnt", blk_cnt, 2);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick;
            seen += int'(adg_read);
        end
        check("w_no_read", seen, 0);
        // illegal commands
        send_cmd(1'b0, 10'h020, 10'd0, 2'b10);
        check("i_len_err", err, 1);
        check("i_len_busy", busy, 0);
        tick;
        check("i_err_1cyc", err, 0);
        send_cmd(1'b0, 10'h020, 10'd8, 2'b01);
        check("i_bw_err", err, 1);
        check("i_bw_busy", busy, 0);
        // command while busy is ignored, then timeout
        send_cmd(1'b0, 10'h020, 10'd8, 2'b00);
        send_cmd(1'b1, 10'h155, 10'd4, 2'b10);
        check("b_no_err", err, 0);
        wait_rd(n);
        check("b_lat", n, 8);
        check("b_ldad", adg_ldad, 10'h020);
        check("b_adln", adg_adln, 10'd8);
        check("b_bw", adg_bw, 2'b00);
        n = 0;
        seen = 0;
        while (!err && n < 40) begin
            tick;
            n++;
            seen += int'(done);
        end
        check("t_err_lat", n, 16);
        check("t_busy", busy, 0);
        check("t_no_done", seen, 0);
        send_cmd(1'b0, 10'h044, 10'd32, 2'b10);
        wait_rd(n);
        check("t_next_lat", n, 9);
        check("t_next_ldad", adg_ldad, 10'h044);
        tick;
        end_blk;
        tick;
        check("t_next_done", done, 1);
        // asynchronous reset in the middle of a block
        send_cmd(1'b0, 10'h2AA, 10'd16, 2'b10);
        wait_rd(n);
        tick;
        rst = 1'b1;
        #2;
        check("r_busy", busy, 0);
        check("r_ldad", adg_ldad, 0);
        check("r_adln", adg_adln, 0);
        tick;
        rst = 1'b0;
        tick;
        end_blk;
        check("r_no_blk_done", blk_done, 0);
        check("r_cnt", blk_cnt, 0);
        tick;
        check("r_no_done", done, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
